// File: rtl/bcd_convert_arbiter_pkg.sv
// bcd_convert_arbiter_pkg: shared constants, state encodings and width helper for the BCD converter
package bcd_convert_arbiter_pkg;
  localparam int N_DEF      = 20;
  localparam int DIGITS_DEF = 6;
  localparam int REQ_DEF    = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  typedef logic [1:0] state_t;
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: request handshake and response bus of the shared converter
interface bcd_convert_arbiter_if
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int REQ    = REQ_DEF
);
  localparam int IW = clog2w(REQ);
  logic [REQ-1:0]      req_valid;
  logic [REQ*N-1:0]    req_data;
  logic [REQ-1:0]      req_ready;
  logic                busy;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [4*DIGITS-1:0] rsp_bcd;
  logic                rsp_ovf;
  modport master (output req_valid, req_data,
                  input  req_ready, busy, rsp_valid, rsp_id, rsp_bcd, rsp_ovf);
  modport slave  (input  req_valid, req_data,
                  output req_ready, busy, rsp_valid, rsp_id, rsp_bcd, rsp_ovf);
endinterface

// File: rtl/bcd_convert_arbiter_dabble_core.sv
// bcd_dabble_core: iterative shift-add-3 datapath with sticky overflow out of the top digit
module bcd_dabble_core
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [N-1:0]        i_operand,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_ovf
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(N+1);
  logic [N-1:0]  r_op;
  logic [BW-1:0] r_bcd;
  logic [BW-1:0] w_adj;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
  end
  // o_bcd/o_ovf are the values after this cycle's shift, so the last step can be captured directly
  assign o_bcd  = {w_adj[BW-2:0], r_op[N-1]};
  assign o_ovf  = r_ovf | w_adj[BW-1];
  assign o_done = r_cnt == CW'(1);
  // Load on start, then shift MSB first until the count runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_op  <= i_operand;
      r_bcd <= '0;
      r_ovf <= 1'b0;
      r_cnt <= CW'(N);
    end else if (r_cnt != '0) begin
      r_op  <= r_op << 1;
      r_bcd <= o_bcd;
      r_ovf <= o_ovf;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin arbiter sharing one sequential binary-to-BCD engine
module bcd_convert_arbiter
  import bcd_convert_arbiter_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int REQ    = REQ_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_convert_arbiter_if.slave bus
);
  localparam int IW = clog2w(REQ);
  localparam int BW = 4*DIGITS;
  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_rsp_id;
  logic [BW-1:0] r_rsp_bcd;
  logic          r_rsp_ovf;
  logic [IW-1:0] w_gid;
  logic [IW-1:0] w_k;
  logic [REQ-1:0] w_gnt;
  logic          w_any;
  logic          w_xfer;
  logic          w_done;
  logic          w_ovf_nxt;
  logic [BW-1:0] w_bcd_nxt;
  logic [N-1:0]  w_operand;
  // Round-robin search for the first valid requester just past the last grant
  always_comb begin
    w_gnt = '0;
    w_gid = '0;
    w_k   = '0;
    w_any = 1'b0;
    for (int j = 1; j <= REQ; j++) begin
      w_k = IW'((int'(r_last) + j) % REQ);
      if (!w_any && bus.req_valid[w_k]) begin
        w_any        = 1'b1;
        w_gid        = w_k;
        w_gnt[w_k]   = 1'b1;
      end
    end
  end
  assign w_xfer        = (r_state == S_IDLE) && w_any;
  assign w_operand     = bus.req_data[int'(w_gid)*N +: N];
  assign bus.req_ready = (r_state == S_IDLE) ? w_gnt : '0;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.rsp_valid = r_state == S_DONE;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_bcd   = r_rsp_bcd;
  assign bus.rsp_ovf   = r_rsp_ovf;
  bcd_dabble_core #(.N(N), .DIGITS(DIGITS)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_xfer),
    .i_operand (w_operand),
    .o_done    (w_done),
    .o_bcd     (w_bcd_nxt),
    .o_ovf     (w_ovf_nxt)
  );
  // Conversion sequencing: IDLE -> SHIFT (N cycles) -> DONE (1 cycle) -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= (r_state == S_IDLE)  ? (w_xfer ? S_SHIFT : S_IDLE) :
                           (r_state == S_SHIFT) ? (w_done ? S_DONE : S_SHIFT) : S_IDLE;
  end
  // Pointer resets to the last requester so requester 0 is searched first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= IW'(REQ-1);
    else if (w_xfer) r_last <= w_gid;
  end
  // Response registers load with the final shift and hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_bcd <= '0;
      r_rsp_ovf <= 1'b0;
      r_rsp_id  <= '0;
    end else if (r_state == S_SHIFT && w_done) begin
      r_rsp_bcd <= w_bcd_nxt;
      r_rsp_ovf <= w_ovf_nxt;
      r_rsp_id  <= r_last;
    end
  end
endmodule
